// File: rtl/uart_reg_responder_pkg.sv
// Shared constants for the UART register responder: opcodes, reply bytes
// and the 3-bit FSM state encoding.
package uart_reg_responder_pkg;

    localparam logic [7:0] OP_W    = 8'h57;
    localparam logic [7:0] OP_R    = 8'h52;
    localparam logic [7:0] OP_P    = 8'h50;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_ADDR = 3'd1;
    localparam logic [2:0] S_GET_DATA = 3'd2;
    localparam logic [2:0] S_BUS_WR   = 3'd3;
    localparam logic [2:0] S_BUS_RD   = 3'd4;
    localparam logic [2:0] S_RD_CAP   = 3'd5;
    localparam logic [2:0] S_SEND     = 3'd6;
    localparam logic [2:0] S_SPARE    = 3'd7;

    function automatic logic known_op(input logic [7:0] b);
        return (b == OP_W) || (b == OP_R) || (b == OP_P);
    endfunction

endpackage

// File: rtl/uart_reg_responder_if.sv
// Byte receiver, byte transmitter and local register bus signals of the responder.
interface uart_reg_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_rd;
    logic       tx_busy;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       cmd_err;
    logic       timeout;

    modport slave (
        input  rx_valid, rx_data, tx_busy, reg_rdata,
        output rx_rd, tx_wr, tx_data, reg_addr, reg_wdata, reg_we, reg_re,
               cmd_err, timeout
    );

    modport master (
        output rx_valid, rx_data, tx_busy, reg_rdata,
        input  rx_rd, tx_wr, tx_data, reg_addr, reg_wdata, reg_we, reg_re,
               cmd_err, timeout
    );

endinterface

// File: rtl/uart_reg_responder_timeout.sv
// Inter-byte watchdog: reloads on clr, counts down while en, flags expiry at zero.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TW             = 24
) (
    input  logic clk,
    input  logic resetq,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TW-1:0] remain;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            remain <= '0;
        else if (clr)
            remain <= TW'(TIMEOUT_CYCLES - 1);
        else if (en && remain != '0)
            remain <= remain - TW'(1);
    end

    assign expire = en && (remain == '0);

endmodule

// File: rtl/uart_reg_responder.sv
// Serial command responder: decodes W/R/P host commands, runs one register
// bus cycle and returns a single reply byte per command.
module uart_reg_responder
    import uart_reg_responder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TW             = 24
) (
    input  logic         clk,
    input  logic         resetq,
    uart_reg_if.slave    bus
);

    logic [2:0] state;
    logic       op_wr;
    logic [7:0] tx_data_q, addr_q, wdata_q;
    logic       waiting, expire;

    assign waiting = (state == S_GET_ADDR) || (state == S_GET_DATA);

    assign bus.rx_rd     = bus.rx_valid && ((state == S_IDLE) || waiting);
    assign bus.reg_we    = (state == S_BUS_WR);
    assign bus.reg_re    = (state == S_BUS_RD);
    assign bus.tx_wr     = (state == S_SEND) && !bus.tx_busy;
    assign bus.cmd_err   = (state == S_IDLE) && bus.rx_valid && !known_op(bus.rx_data);
    // A byte landing on the expiry cycle takes priority over the timeout.
    assign bus.timeout   = waiting && expire && !bus.rx_valid;
    assign bus.tx_data   = tx_data_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;

    uart_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TW(TW)) u_timeout (
        .clk    (clk),
        .resetq (resetq),
        .clr    (bus.rx_rd || !waiting),
        .en     (waiting),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state     <= S_IDLE;
            op_wr     <= 1'b0;
            tx_data_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.rx_valid) begin
                    case (bus.rx_data)
                        OP_W, OP_R: begin
                            op_wr <= (bus.rx_data == OP_W);
                            state <= S_GET_ADDR;
                        end
                        OP_P: begin
                            tx_data_q <= RSP_OK;
                            state     <= S_SEND;
                        end
                        default: begin
                            tx_data_q <= RSP_ERR;
                            state     <= S_SEND;
                        end
                    endcase
                end
                S_GET_ADDR: begin
                    if (bus.rx_valid) begin
                        addr_q <= bus.rx_data;
                        state  <= op_wr ? S_GET_DATA : S_BUS_RD;
                    end else if (expire) begin
                        state <= S_IDLE;
                    end
                end
                S_GET_DATA: begin
                    if (bus.rx_valid) begin
                        wdata_q <= bus.rx_data;
                        state   <= S_BUS_WR;
                    end else if (expire) begin
                        state <= S_IDLE;
                    end
                end
                S_BUS_WR: begin
                    tx_data_q <= RSP_OK;
                    state     <= S_SEND;
                end
                S_BUS_RD: state <= S_RD_CAP;
                // Read data is valid exactly one cycle after the strobe.
                S_RD_CAP: begin
                    tx_data_q <= bus.reg_rdata;
                    state     <= S_SEND;
                end
                S_SEND: if (!bus.tx_busy) state <= S_IDLE;
                S_SPARE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed plus randomized command stream checked against a byte-level
// register-file reference model.
module tb_uart_reg_responder;

    localparam int TO = 100;

    logic clk = 1'b0;
    logic resetq = 1'b0;

    uart_reg_if u_if();

    uart_reg_responder #(.TIMEOUT_CYCLES(TO), .TW(24)) dut (
        .clk    (clk),
        .resetq (resetq),
        .bus    (u_if.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int n_tx = 0, n_we = 0, n_re = 0, n_err = 0, n_to = 0;
    int last_rd = 0, tx_cyc = 0, to_cyc = 0;
    logic [7:0] last_tx = '0, we_addr = '0, we_data = '0, re_addr = '0;

    logic [7:0] periph  [256];
    logic [7:0] ref_mem [256];

    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral: writes land on the strobe edge, read data appears one cycle after reg_re.
    always @(posedge clk) begin
        if (u_if.reg_we) periph[u_if.reg_addr] <= u_if.reg_wdata;
        u_if.reg_rdata <= u_if.reg_re ? periph[u_if.reg_addr] : 8'($urandom);
    end

    always @(negedge clk) begin
        if (resetq) begin
            if (u_if.rx_rd) last_rd <= cyc;
            if (u_if.tx_wr) begin
                n_tx <= n_tx + 1; last_tx <= u_if.tx_data; tx_cyc <= cyc;
            end
            if (u_if.reg_we) begin
                n_we <= n_we + 1; we_addr <= u_if.reg_addr; we_data <= u_if.reg_wdata;
            end
            if (u_if.reg_re) begin
                n_re <= n_re + 1; re_addr <= u_if.reg_addr;
            end
            if (u_if.cmd_err) n_err <= n_err + 1;
            if (u_if.timeout) begin
                n_to <= n_to + 1; to_cyc <= cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (u_if.rx_rd) got = 1'b1;
        end
        @(posedge clk); #1;
        u_if.rx_valid = 1'b0;
        if (!got) chk("rx_consume", 0, 1);
    endtask

    task automatic wait_reply(input int tx0, output logic [7:0] d, output int lat);
        int i;
        i = 0;
        while (n_tx == tx0 && i < 100) begin
            @(posedge clk); #1;
            i++;
        end
        if (n_tx == tx0) chk("reply_wait", 0, 1);
        d   = last_tx;
        lat = tx_cyc - last_rd;
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data);
        int tx0, we0, re0, err0, to0, exp_lat, lat;
        int exp_we, exp_re, exp_err;
        logic [7:0] exp_d, got;
        tx0 = n_tx; we0 = n_we; re0 = n_re; err0 = n_err; to0 = n_to;
        exp_we = 0; exp_re = 0; exp_err = 0;
        send_byte(op);
        if (op == 8'h57) begin
            send_byte(addr); send_byte(data);
            ref_mem[addr] = data;
            exp_d = 8'h4B; exp_lat = 2; exp_we = 1;
        end else if (op == 8'h52) begin
            send_byte(addr);
            exp_d = ref_mem[addr]; exp_lat = 3; exp_re = 1;
        end else if (op == 8'h50) begin
            exp_d = 8'h4B; exp_lat = 1;
        end else begin
            exp_d = 8'h3F; exp_lat = 1; exp_err = 1;
        end
        wait_reply(tx0, got, lat);
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("reply_%0h", op), 32'(got), 32'(exp_d));
        chk($sformatf("latency_%0h", op), lat, exp_lat);
        chk($sformatf("tx_count_%0h", op), n_tx - tx0, 1);
        chk($sformatf("we_count_%0h", op), n_we - we0, exp_we);
        chk($sformatf("re_count_%0h", op), n_re - re0, exp_re);
        chk($sformatf("err_count_%0h", op), n_err - err0, exp_err);
        chk($sformatf("to_count_%0h", op), n_to - to0, 0);
        if (exp_we != 0) begin
            chk("we_addr", 32'(we_addr), 32'(addr));
            chk("we_data", 32'(we_data), 32'(data));
        end
        if (exp_re != 0) chk("re_addr", 32'(re_addr), 32'(addr));
    endtask

    initial begin
        int c, tx0, to0, we0, bad, lat, sel;
        logic [7:0] got, a, d, o;

        u_if.rx_valid = 1'b0;
        u_if.rx_data  = '0;
        u_if.tx_busy  = 1'b0;
        for (int i = 0; i < 256; i++) begin
            periph[i]  = 8'($urandom);
            ref_mem[i] = periph[i];
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({u_if.rx_rd, u_if.tx_wr, u_if.tx_data, u_if.reg_addr,
            u_if.reg_wdata, u_if.reg_we, u_if.reg_re, u_if.cmd_err, u_if.timeout}), 0);
        resetq = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed: write, read, unknown opcode, ping
        do_cmd(8'h57, 8'h12, 8'hA5);
        chk("periph_write", 32'(periph[8'h12]), 32'hA5);
        periph[8'h34] = 8'hC3; ref_mem[8'h34] = 8'hC3;
        do_cmd(8'h52, 8'h34, 8'h00);
        do_cmd(8'h00, 8'h00, 8'h00);
        do_cmd(8'h50, 8'h00, 8'h00);

        // Busy backpressure on a ping, with a second ping pending in the receiver
        u_if.tx_busy = 1'b1;
        send_byte(8'h50);
        u_if.rx_data = 8'h50; u_if.rx_valid = 1'b1;
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (u_if.tx_wr || u_if.rx_rd) bad++;
        end
        chk("busy_hold", bad, 0);
        @(posedge clk); #1;
        u_if.tx_busy = 1'b0;
        @(negedge clk);
        chk("busy_release_wr", 32'(u_if.tx_wr), 1);
        chk("busy_release_data", 32'(u_if.tx_data), 32'h4B);
        @(posedge clk); #1;
        tx0 = n_tx;
        send_byte(8'h50);
        wait_reply(tx0, got, lat);
        chk("pending_ping", 32'(got), 32'h4B);

        // Timeout waiting for the data byte
        to0 = n_to; tx0 = n_tx; we0 = n_we;
        send_byte(8'h57); send_byte(8'h12);
        c = last_rd;
        repeat (150) @(posedge clk);
        #1;
        chk("to_data_count", n_to - to0, 1);
        chk("to_data_delay", to_cyc - c, TO);
        chk("to_data_no_we", n_we - we0, 0);
        chk("to_data_no_tx", n_tx - tx0, 0);
        do_cmd(8'h50, 8'h00, 8'h00);

        // Timeout waiting for the address byte
        to0 = n_to; tx0 = n_tx;
        send_byte(8'h52);
        c = last_rd;
        repeat (150) @(posedge clk);
        #1;
        chk("to_addr_count", n_to - to0, 1);
        chk("to_addr_delay", to_cyc - c, TO);
        chk("to_addr_no_tx", n_tx - tx0, 0);

        // Byte arriving on the expiry cycle wins over the timeout
        to0 = n_to; tx0 = n_tx;
        send_byte(8'h57);
        c = last_rd;
        repeat (99) @(posedge clk);
        #1;
        send_byte(8'h15);
        chk("edge_rd_cycle", last_rd - c, TO);
        send_byte(8'h6E);
        ref_mem[8'h15] = 8'h6E;
        wait_reply(tx0, got, lat);
        chk("edge_reply", 32'(got), 32'h4B);
        chk("edge_no_timeout", n_to - to0, 0);
        chk("edge_periph", 32'(periph[8'h15]), 32'h6E);

        // Reset while in BUS_RD
        send_byte(8'h52); send_byte(8'h34);
        chk("pre_reset_re", 32'(u_if.reg_re), 1);
        resetq = 1'b0;
        #1;
        chk("midop_reset_outputs", 32'({u_if.rx_rd, u_if.tx_wr, u_if.tx_data, u_if.reg_addr,
            u_if.reg_wdata, u_if.reg_we, u_if.reg_re, u_if.cmd_err, u_if.timeout}), 0);
        tx0 = n_tx;
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("reset_no_reply", n_tx - tx0, 0);
        do_cmd(8'h50, 8'h00, 8'h00);

        // Randomized command stream
        for (int k = 0; k < 40; k++) begin
            sel = int'($urandom_range(0, 3));
            a = 8'h10 + 8'($urandom_range(0, 7));
            d = 8'($urandom);
            case (sel)
                0: o = 8'h57;
                1: o = 8'h52;
                2: o = 8'h50;
                default: begin
                    o = 8'($urandom);
                    if (o == 8'h57 || o == 8'h52 || o == 8'h50) o = o ^ 8'h01;
                end
            endcase
            do_cmd(o, a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
